core_ctrl: RTL and testbench

- Instruction sequencer for the `core` datapath. It drives the 34-bit `inst` word so that one full convolution layer runs without a bench-driven instruction stream.
- For each kernel index kij it performs, in order: load weights from xmem into L0, push the weights into the PE array, reload activations into L0, execute, and drain the ofifo into pmem with accumulation.
- It sits between the top-level start/done handshake and `core.inst`, and observes `core.valid` (ofifo_valid).

---
 rtl/core_ctrl.sv | 156 +++++++++++++++
 tb/tb_core_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - per-layer instruction sequencer driving core.inst
// Walks weight load, weight push, activation load, execute and ofifo drain for every kernel index.
module core_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int a_base  = 0,
  parameter int w_base  = 64,
  parameter int p_base  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  typedef enum logic [2:0] {
    IDLE, WLOAD, KLOAD, KWAIT, ALOAD, EXEC, DRAIN, FIN
  } state_t;

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;
  localparam logic [10:0] ROW       = 11'(row);
  localparam logic [10:0] COL       = 11'(col);
  localparam logic [10:0] NIJ       = 11'(len_nij);
  localparam logic [10:0] ABASE     = 11'(a_base);
  localparam logic [10:0] WBASE     = 11'(w_base);
  localparam logic [10:0] PBASE     = 11'(p_base);
  localparam logic [3:0]  LAST_KIJ  = 4'(len_kij - 1);

  state_t      state, state_n;
  logic [10:0] cnt, cnt_n;
  logic [10:0] ocnt, ocnt_n;
  logic [3:0]  kij_n;
  logic [33:0] inst_n;
  logic [10:0] w_addr;

  // All address math is 11 bits and wraps silently.
  assign w_addr = WBASE + 11'(kij) * COL + cnt;

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 11'd1;
    ocnt_n  = ocnt;
    kij_n   = kij;
    inst_n  = IDLE_WORD;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          state_n = WLOAD;
          kij_n   = '0;
        end
      end
      WLOAD: begin
        if (cnt < COL) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = w_addr;
        end
        if (cnt != '0) inst_n[2] = 1'b1;
        if (cnt == COL) begin
          state_n = KLOAD;
          cnt_n   = '0;
        end
      end
      KLOAD: begin
        inst_n[3] = 1'b1;
        inst_n[0] = 1'b1;
        if (cnt == COL - 11'd1) begin
          state_n = KWAIT;
          cnt_n   = '0;
        end
      end
      KWAIT: begin
        if (cnt == ROW - 11'd1) begin
          state_n = ALOAD;
          cnt_n   = '0;
        end
      end
      ALOAD: begin
        if (cnt < NIJ) begin
          inst_n[19]   = 1'b0;
          inst_n[17:7] = ABASE + cnt;
        end
        if (cnt != '0) inst_n[2] = 1'b1;
        if (cnt == NIJ) begin
          state_n = EXEC;
          cnt_n   = '0;
        end
      end
      EXEC: begin
        inst_n[3] = 1'b1;
        inst_n[1] = 1'b1;
        if (cnt == NIJ - 11'd1) begin
          state_n = DRAIN;
          cnt_n   = '0;
          ocnt_n  = '0;
        end
      end
      DRAIN: begin
        cnt_n = cnt;
        if (ocnt == NIJ) begin
          cnt_n  = '0;
          ocnt_n = '0;
          if (kij == LAST_KIJ) begin
            state_n = FIN;
          end else begin
            kij_n   = kij + 4'd1;
            state_n = WLOAD;
          end
        // inst[6] is last cycle's read; skipping after a read absorbs the valid lag.
        end else if (ofifo_valid && !inst[6]) begin
          inst_n[33]    = (kij != 4'd0);
          inst_n[32]    = 1'b0;
          inst_n[31]    = 1'b0;
          inst_n[30:20] = PBASE + ocnt;
          inst_n[6]     = 1'b1;
          ocnt_n        = ocnt + 11'd1;
        end
      end
      FIN: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ocnt  <= '0;
      kij   <= '0;
      inst  <= IDLE_WORD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ocnt  <= ocnt_n;
      kij   <= kij_n;
      inst  <= inst_n;
      busy  <= (state_n != IDLE);
      done  <= (state == FIN);
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - self-checking bench for core_ctrl
// Reset/start table, full-layer logs analysed against a word-level layer model, mid-layer reset.
module tb_core_ctrl;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
  localparam int ROW = 8, COL = 8, NKIJ = 9, NIJ = 36;
  localparam int ABASE = 0, WBASE = 64, PBASE = 0, MAXL = 8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy, done;
  logic [3:0]  kij;

  int nvec = 0, nerr = 0;

  logic [33:0] li [MAXL];
  logic        lv [MAXL];
  logic        lb [MAXL];
  logic        ld [MAXL];
  logic [3:0]  lk [MAXL];
  int          nlog, done_idx;

  typedef struct {
    logic        rst;
    logic        st;
    logic [33:0] ei;
    logic        eb;
    logic        ed;
    logic [3:0]  ek;
  } vec_t;
  vec_t tv [9];

  core_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .kij(kij)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] xrd(input int a, input logic wr);
    logic [33:0] w;
    w        = IDLE_W;
    w[19]    = 1'b0;
    w[17:7]  = 11'(a);
    w[2]     = wr;
    return w;
  endfunction

  function automatic logic [33:0] pw(input int a, input logic acc);
    logic [33:0] w;
    w        = IDLE_W;
    w[33]    = acc;
    w[32]    = 1'b0;
    w[31]    = 1'b0;
    w[30:20] = 11'(a);
    w[6]     = 1'b1;
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // mode 0: valid always high; mode 1: random valid with a 50-cycle hole at stall_at.
  task automatic run_layer(input int mode, input int stall_at);
    logic v;
    done_idx = -1;
    nlog     = MAXL;
    @(negedge clk);
    start = 1'b1;
    for (int n = 0; n < MAXL; n++) begin
      @(negedge clk);
      start = 1'b0;
      li[n] = inst; lb[n] = busy; ld[n] = done; lk[n] = kij;
      if (mode == 0) v = 1'b1;
      else if (n >= stall_at && n < stall_at + 50) v = 1'b0;
      else v = ($urandom_range(0, 3) != 0);
      ofifo_valid = v;
      lv[n] = v;
      if (done_idx < 0 && done) done_idx = n;
      if (done_idx >= 0 && n == done_idx + 2) begin
        nlog = n + 1;
        break;
      end
    end
    ofifo_valid = 1'b0;
    chk("layer_done_seen", 34'(done_idx >= 0), 34'(1));
  endtask

  task automatic analyze();
    logic [33:0] q[$];
    int p, ocnt, g, nd, npw, nwr, nar;
    logic rd;
    p = 0;
    while (p < 4 && li[p] == IDLE_W) p++;
    for (int k = 0; k < NKIJ; k++) begin
      q.delete();
      for (int c = 0; c <= COL; c++) q.push_back(c < COL ? xrd(WBASE + k*COL + c, c != 0) : (IDLE_W | 34'h4));
      for (int c = 0; c < COL; c++)  q.push_back(IDLE_W | 34'h9);
      for (int c = 0; c < ROW; c++)  q.push_back(IDLE_W);
      for (int c = 0; c <= NIJ; c++) q.push_back(c < NIJ ? xrd(ABASE + c, c != 0) : (IDLE_W | 34'h4));
      for (int c = 0; c < NIJ; c++)  q.push_back(IDLE_W | 34'hA);
      foreach (q[i]) begin
        if (p >= nlog) begin
          chk("log_short", 34'(p), 34'(nlog - 1));
          return;
        end
        chk("seq_word", li[p], q[i]);
        chk("seq_kij", 34'(lk[p]), 34'(k));
        p++;
      end
      ocnt = 0;
      while (ocnt < NIJ && p < nlog) begin
        rd = lv[p-1] && !li[p-1][6];
        chk("drain_word", li[p], rd ? pw(PBASE + ocnt, k != 0) : IDLE_W);
        if (rd) ocnt++;
        p++;
      end
      if (ocnt < NIJ) begin
        chk("drain_reads", 34'(ocnt), 34'(NIJ));
        return;
      end
      g = 0;
      while (p < nlog && li[p] == IDLE_W && g < 8) begin
        p++;
        g++;
      end
      if (k < NKIJ - 1) chk("kij_gap_bounded", 34'(g < 8), 34'(1));
    end
    nd = 0; npw = 0; nwr = 0; nar = 0;
    for (int n = 0; n < nlog; n++) begin
      if (ld[n]) nd++;
      if (!li[n][32] && !li[n][31]) npw++;
      if (!li[n][19] && li[n][17:7] >= 11'(WBASE)) nwr++;
      if (!li[n][19] && li[n][17:7] < 11'(WBASE)) nar++;
    end
    chk("done_pulses", 34'(nd), 34'(1));
    chk("busy_after_done", 34'(lb[done_idx+1]), 34'(0));
    chk("pmem_writes", 34'(npw), 34'(NKIJ*NIJ));
    chk("weight_reads", 34'(nwr), 34'(NKIJ*COL));
    chk("act_reads", 34'(nar), 34'(NKIJ*NIJ));
  endtask

  initial begin
    logic found;
    reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_inst", inst, IDLE_W);
      chk("idle_busy", 34'(busy), 34'(0));
      chk("idle_done", 34'(done), 34'(0));
    end

    tv[0] = '{1'b1, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
    tv[1] = '{1'b1, 1'b1, IDLE_W,           1'b0, 1'b0, 4'd0};
    tv[2] = '{1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
    tv[3] = '{1'b0, 1'b1, IDLE_W,           1'b1, 1'b0, 4'd0};
    tv[4] = '{1'b0, 1'b0, xrd(64, 1'b0),    1'b1, 1'b0, 4'd0};
    tv[5] = '{1'b0, 1'b1, xrd(65, 1'b1),    1'b1, 1'b0, 4'd0};
    tv[6] = '{1'b0, 1'b0, xrd(66, 1'b1),    1'b1, 1'b0, 4'd0};
    tv[7] = '{1'b1, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
    tv[8] = '{1'b0, 1'b0, IDLE_W,           1'b0, 1'b0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      reset = tv[i].rst;
      start = tv[i].st;
      @(negedge clk);
      chk($sformatf("tbl%0d_inst", i), inst, tv[i].ei);
      chk($sformatf("tbl%0d_busy", i), 34'(busy), 34'(tv[i].eb));
      chk($sformatf("tbl%0d_done", i), 34'(done), 34'(tv[i].ed));
      chk($sformatf("tbl%0d_kij", i), 34'(kij), 34'(tv[i].ek));
    end
    start = 1'b0;

    do_reset();
    run_layer(0, 0);
    if (done_idx >= 0) analyze();

    do_reset();
    run_layer(1, 110 + $urandom_range(0, 10));
    if (done_idx >= 0) analyze();

    do_reset();
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 5000; t++) begin
      if (kij == 4'd4 && inst[1]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("kij4_exec_reached", 34'(found), 34'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ofifo_valid = 1'b0;
    chk("midrst_inst", inst, IDLE_W);
    chk("midrst_kij", 34'(kij), 34'(0));
    chk("midrst_busy", 34'(busy), 34'(0));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 34'(busy), 34'(1));
    @(negedge clk);
    chk("restart_first_read", inst, xrd(64, 1'b0));
    chk("restart_kij", 34'(kij), 34'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
